// File: rtl/ifm_window_loader.sv
// ---------------------------------------------------------------------------
// ifm_window_loader
//
// Upstream feeder for the 4x8 convolution stage. IFM pixels arrive one at a
// time over a valid/ready stream. They are assembled in row-major order into
// one of two window banks. A completed bank is presented in parallel to the
// convolution engine with its own valid/ready handshake. While one bank is
// waiting to be consumed, the other bank can be filled.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous, active-low reset
//   s_valid     input pixel valid
//   s_ready     loader can accept a pixel (registered)
//   s_data      pixel value, unsigned, PIX_W bits
//   s_last      marks the last pixel of a window
//   conv_valid  a complete window is presented on conv_ifm
//   conv_ready  downstream accepts the presented window
//   conv_ifm    NPIX pixels; pixel k = conv_ifm[PIX_W*k +: PIX_W],
//               row k/COLS, column k%COLS
//   err_len     one-cycle pulse when a window length and s_last disagree
//   win_cnt     number of windows handed downstream, wraps
// ---------------------------------------------------------------------------
module ifm_window_loader #(
   parameter int PIX_W = 4,
   parameter int ROWS  = 4,
   parameter int COLS  = 8,
   parameter int CNT_W = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        s_valid,
   output logic                        s_ready,
   input  logic [PIX_W-1:0]            s_data,
   input  logic                        s_last,
   output logic                        conv_valid,
   input  logic                        conv_ready,
   output logic [ROWS*COLS*PIX_W-1:0]  conv_ifm,
   output logic                        err_len,
   output logic [CNT_W-1:0]            win_cnt
);

   localparam int NPIX  = ROWS * COLS;
   localparam int WIN_W = NPIX * PIX_W;
   localparam int PC_W  = $clog2(NPIX);
   localparam logic [PC_W-1:0] LAST_IDX = PC_W'(NPIX - 1);

   logic [WIN_W-1:0] bank_q [2];
   logic [WIN_W-1:0] bank_d [2];
   logic [1:0]       full_q, full_d;
   logic             wr_bank_q, wr_bank_d;
   logic             rd_bank_q, rd_bank_d;
   logic [PC_W-1:0]  pix_cnt_q, pix_cnt_d;
   logic             s_ready_q, s_ready_d;
   logic             conv_valid_q, conv_valid_d;
   logic [WIN_W-1:0] conv_ifm_q, conv_ifm_d;
   logic             err_len_q, err_len_d;
   logic [CNT_W-1:0] win_cnt_q, win_cnt_d;

   logic accept;
   logic xfer;
   logic at_last;

   // Next-state logic. Writes only ever target the write bank, and a pixel is
   // only accepted while that bank is empty. A presented (full) bank is
   // therefore never modified, which keeps conv_ifm stable under
   // backpressure. A close and a transfer always address different banks
   // (one is empty, the other full), so both can be applied in the same cycle.
   always_comb begin
      bank_d[0]     = bank_q[0];
      bank_d[1]     = bank_q[1];
      full_d        = full_q;
      wr_bank_d     = wr_bank_q;
      rd_bank_d     = rd_bank_q;
      pix_cnt_d     = pix_cnt_q;
      err_len_d     = 1'b0;
      win_cnt_d     = win_cnt_q;

      accept  = s_valid & s_ready_q;
      xfer    = conv_valid_q & conv_ready;
      at_last = (pix_cnt_q == LAST_IDX);

      if (accept) begin
         bank_d[wr_bank_q][PIX_W*int'(pix_cnt_q) +: PIX_W] = s_data;
         if (at_last) begin
            // A full-length window is committed even if s_last is missing;
            // the missing marker is only reported.
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
            pix_cnt_d         = '0;
            err_len_d         = ~s_last;
         end else if (s_last) begin
            // Short window: restart the fill in the same bank. Stale pixels
            // left behind are overwritten by the next full window.
            pix_cnt_d = '0;
            err_len_d = 1'b1;
         end else begin
            pix_cnt_d = pix_cnt_q + 1'b1;
         end
      end

      if (xfer) begin
         full_d[rd_bank_q] = 1'b0;
         rd_bank_d         = ~rd_bank_q;
         win_cnt_d         = win_cnt_q + 1'b1;
      end

      // Outputs are registered from the next state, so they describe the
      // state the loader holds in the coming cycle. No path runs from
      // conv_ready to s_ready in the same cycle.
      s_ready_d    = ~full_d[wr_bank_d];
      conv_valid_d = full_d[rd_bank_d];
      conv_ifm_d   = full_d[rd_bank_d] ? bank_d[rd_bank_d] : '0;
   end

   // State registers. s_ready is held low throughout reset and rises on the
   // first clock edge after reset is released.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bank_q[0]    <= '0;
         bank_q[1]    <= '0;
         full_q       <= '0;
         wr_bank_q    <= 1'b0;
         rd_bank_q    <= 1'b0;
         pix_cnt_q    <= '0;
         s_ready_q    <= 1'b0;
         conv_valid_q <= 1'b0;
         conv_ifm_q   <= '0;
         err_len_q    <= 1'b0;
         win_cnt_q    <= '0;
      end else begin
         bank_q[0]    <= bank_d[0];
         bank_q[1]    <= bank_d[1];
         full_q       <= full_d;
         wr_bank_q    <= wr_bank_d;
         rd_bank_q    <= rd_bank_d;
         pix_cnt_q    <= pix_cnt_d;
         s_ready_q    <= s_ready_d;
         conv_valid_q <= conv_valid_d;
         conv_ifm_q   <= conv_ifm_d;
         err_len_q    <= err_len_d;
         win_cnt_q    <= win_cnt_d;
      end
   end

   assign s_ready    = s_ready_q;
   assign conv_valid = conv_valid_q;
   assign conv_ifm   = conv_ifm_q;
   assign err_len    = err_len_q;
   assign win_cnt    = win_cnt_q;

endmodule

// File: tb/tb_ifm_window_loader.sv
// ---------------------------------------------------------------------------
// tb_ifm_window_loader
//
// Self-checking bench for ifm_window_loader. Pixels are driven on the falling
// edge. Outputs are sampled just after the falling edge. A small reference
// model rebuilds every expected window from the pixels actually accepted.
// A monitor compares each delivered window against that model, counts
// err_len pulses, and confirms that held windows stay stable.
// ---------------------------------------------------------------------------
module tb_ifm_window_loader;

   localparam int PIX_W = 4;
   localparam int NPIX  = 32;
   localparam int WIN_W = NPIX * PIX_W;

   logic             clk;
   logic             rst_n;
   logic             s_valid;
   logic             s_ready;
   logic [3:0]       s_data;
   logic             s_last;
   logic             conv_valid;
   logic             conv_ready;
   logic [WIN_W-1:0] conv_ifm;
   logic             err_len;
   logic [15:0]      win_cnt;

   ifm_window_loader dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_data     (s_data),
      .s_last     (s_last),
      .conv_valid (conv_valid),
      .conv_ready (conv_ready),
      .conv_ifm   (conv_ifm),
      .err_len    (err_len),
      .win_cnt    (win_cnt)
   );

   // Directed vector record: pixel count, data base, s_last spacing (0 = never),
   // and the hand-computed err_len pulses and windows delivered.
   typedef struct {
      int n_pix;
      int base;
      int last_every;
      int exp_err;
      int exp_win;
   } vec_t;

   int check_count = 0;
   int fail_count  = 0;

   int cyc = 0;
   int hs_count = 0;
   int err_seen = 0;
   int hs_cyc[$];
   logic [WIN_W-1:0] exp_q[$];
   logic [WIN_W-1:0] model_win;
   int model_idx;
   logic hold_prev;
   logic [WIN_W-1:0] held_val;
   int exp_total;

   // Free-running clock and a cycle counter for handshake spacing.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // Global time limit so the bench always ends on its own.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [WIN_W-1:0] actual,
                              input logic [WIN_W-1:0] expected);
      check_count++;
      if (actual !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   // Reference model: collects the accepted pixels and queues each full window.
   task automatic modelAccept(input logic [3:0] d, input logic last);
      model_win[PIX_W*model_idx +: PIX_W] = d;
      if (model_idx == NPIX - 1) begin
         exp_q.push_back(model_win);
         model_idx = 0;
      end else if (last) begin
         model_idx = 0;
      end else begin
         model_idx++;
      end
   endtask

   // Offer one pixel. Must be called on a falling edge. It returns on the
   // falling edge after the pixel is accepted, or after the stall bound expires.
   task automatic applyStimulus(input logic [3:0] d, input logic last,
                                output int stalls, output bit ok);
      s_valid = 1'b1;
      s_data  = d;
      s_last  = last;
      stalls  = 0;
      while (!s_ready && stalls < 300) begin
         @(negedge clk);
         stalls++;
      end
      if (!s_ready) begin
         ok = 1'b0;
      end else begin
         @(posedge clk);
         modelAccept(d, last);
         @(negedge clk);
         ok = 1'b1;
      end
   endtask

   // Stream n pixels back to back. Pixel k = base + k + 5*(k/32), mod 16.
   // Consecutive windows therefore differ.
   task automatic sendPixels(input int n, input int base, input int last_every,
                             output int stalls_total);
      int st;
      bit ok;
      logic [3:0] d;
      logic last;
      stalls_total = 0;
      for (int k = 0; k < n; k++) begin
         d    = 4'((base + k + 5 * (k / 32)) % 16);
         last = (last_every != 0) && (((k + 1) % last_every) == 0);
         applyStimulus(d, last, st, ok);
         stalls_total += st;
         if (!ok) begin
            checkOutput("s_ready timeout", '0, WIN_W'(1));
            break;
         end
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic modelReset();
      exp_q.delete();
      model_idx = 0;
      model_win = '0;
   endtask

   // Output monitor, sampled 1 time unit after each falling edge.
   initial begin
      hold_prev = 1'b0;
      held_val  = '0;
      forever begin
         @(negedge clk);
         #1;
         if (rst_n && conv_valid && conv_ready) begin
            hs_count++;
            hs_cyc.push_back(cyc);
            if (exp_q.size() == 0)
               checkOutput("unexpected window", conv_ifm, '0);
            else
               checkOutput("window data", conv_ifm, exp_q.pop_front());
         end
         if (rst_n && err_len)
            err_seen++;
         if (!conv_valid)
            checkOutput("ifm zero when idle", conv_ifm, '0);
         if (hold_prev && rst_n) begin
            checkOutput("held valid", WIN_W'(conv_valid), WIN_W'(1));
            checkOutput("held data", conv_ifm, held_val);
         end
         hold_prev = rst_n && conv_valid && !conv_ready;
         held_val  = conv_ifm;
      end
   end

   initial begin
      vec_t vecs[5];
      int st;
      int err0;
      int hs0;
      logic [WIN_W-1:0] first_win;

      vecs[0] = '{n_pix: 10, base: 0, last_every: 10, exp_err: 1, exp_win: 0};
      vecs[1] = '{n_pix: 32, base: 3, last_every: 32, exp_err: 0, exp_win: 1};
      vecs[2] = '{n_pix: 32, base: 7, last_every: 0,  exp_err: 1, exp_win: 1};
      vecs[3] = '{n_pix: 64, base: 5, last_every: 32, exp_err: 0, exp_win: 2};
      vecs[4] = '{n_pix: 32, base: 9, last_every: 32, exp_err: 0, exp_win: 1};

      modelReset();
      s_valid    = 1'b0;
      s_data     = '0;
      s_last     = 1'b0;
      conv_ready = 1'b1;
      rst_n      = 1'b0;
      exp_total  = 0;

      // Outputs while reset is asserted.
      repeat (3) @(negedge clk);
      #1;
      checkOutput("reset s_ready", WIN_W'(s_ready), '0);
      checkOutput("reset conv_valid", WIN_W'(conv_valid), '0);
      checkOutput("reset conv_ifm", conv_ifm, '0);
      checkOutput("reset err_len", WIN_W'(err_len), '0);
      checkOutput("reset win_cnt", WIN_W'(win_cnt), '0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("s_ready after reset", WIN_W'(s_ready), WIN_W'(1));

      // Single window: presented right after the last accept, for one cycle.
      $display("[TB] single window latency");
      sendPixels(32, 0, 32, st);
      checkOutput("first window valid", WIN_W'(conv_valid), WIN_W'(1));
      checkOutput("first pixel", WIN_W'(conv_ifm[3:0]), WIN_W'(0));
      checkOutput("last pixel", WIN_W'(conv_ifm[127:124]), WIN_W'(15));
      @(negedge clk);
      checkOutput("valid one cycle", WIN_W'(conv_valid), '0);
      checkOutput("win_cnt after first", WIN_W'(win_cnt), WIN_W'(1));
      checkOutput("no err first", WIN_W'(err_seen), '0);
      exp_total = 1;

      // Directed vectors with a free-running consumer.
      for (int v = 0; v < 5; v++) begin
         $display("[TB] vector %0d: %0d pixels base %0d", v, vecs[v].n_pix, vecs[v].base);
         err0 = err_seen;
         hs0  = hs_count;
         sendPixels(vecs[v].n_pix, vecs[v].base, vecs[v].last_every, st);
         repeat (3) @(negedge clk);
         exp_total += vecs[v].exp_win;
         checkOutput("vec err pulses", WIN_W'(err_seen - err0), WIN_W'(vecs[v].exp_err));
         checkOutput("vec windows", WIN_W'(hs_count - hs0), WIN_W'(vecs[v].exp_win));
         checkOutput("vec win_cnt", WIN_W'(win_cnt), WIN_W'(exp_total));
         checkOutput("vec no stalls", WIN_W'(st), '0);
         checkOutput("vec pending", WIN_W'(exp_q.size()), '0);
         if (vecs[v].exp_win == 2)
            checkOutput("back-to-back spacing",
                        WIN_W'(hs_cyc[hs_cyc.size()-1] - hs_cyc[hs_cyc.size()-2]), WIN_W'(32));
      end

      // Backpressure: both banks fill, the first window is held, then the
      // consumer resumes while a third window is waiting to load.
      $display("[TB] backpressure");
      conv_ready = 1'b0;
      hs0 = hs_count;
      sendPixels(64, 2, 32, st);
      checkOutput("bp no stall while filling", WIN_W'(st), '0);
      checkOutput("bp s_ready low", WIN_W'(s_ready), '0);
      checkOutput("bp valid held", WIN_W'(conv_valid), WIN_W'(1));
      first_win = exp_q[0];
      checkOutput("bp first window", conv_ifm, first_win);
      repeat (5) @(negedge clk);
      checkOutput("bp first window later", conv_ifm, first_win);
      checkOutput("bp s_ready still low", WIN_W'(s_ready), '0);
      checkOutput("bp win_cnt frozen", WIN_W'(win_cnt), WIN_W'(exp_total));
      fork
         sendPixels(32, 11, 32, st);
         begin
            repeat (4) @(negedge clk);
            conv_ready = 1'b1;
         end
      join
      repeat (3) @(negedge clk);
      exp_total += 3;
      checkOutput("bp windows", WIN_W'(hs_count - hs0), WIN_W'(3));
      checkOutput("bp consecutive", WIN_W'(hs_cyc[hs0+1] - hs_cyc[hs0]), WIN_W'(1));
      checkOutput("bp third stalled", WIN_W'(st > 0), WIN_W'(1));
      checkOutput("bp s_ready back", WIN_W'(s_ready), WIN_W'(1));
      checkOutput("bp win_cnt", WIN_W'(win_cnt), WIN_W'(exp_total));
      checkOutput("bp pending", WIN_W'(exp_q.size()), '0);

      // Reset with one window held and a partial window in progress.
      $display("[TB] reset mid-window");
      conv_ready = 1'b0;
      sendPixels(32, 4, 32, st);
      sendPixels(20, 8, 0, st);
      rst_n = 1'b0;
      modelReset();
      #1;
      checkOutput("mid reset s_ready", WIN_W'(s_ready), '0);
      checkOutput("mid reset conv_valid", WIN_W'(conv_valid), '0);
      checkOutput("mid reset conv_ifm", conv_ifm, '0);
      checkOutput("mid reset err_len", WIN_W'(err_len), '0);
      checkOutput("mid reset win_cnt", WIN_W'(win_cnt), '0);
      repeat (2) @(negedge clk);
      rst_n      = 1'b1;
      conv_ready = 1'b1;
      @(negedge clk);
      hs0 = hs_count;
      sendPixels(32, 13, 32, st);
      repeat (3) @(negedge clk);
      checkOutput("post reset windows", WIN_W'(hs_count - hs0), WIN_W'(1));
      checkOutput("post reset win_cnt", WIN_W'(win_cnt), WIN_W'(1));
      checkOutput("post reset pending", WIN_W'(exp_q.size()), '0);

      $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
      $finish;
   end

endmodule
